// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO in front of a UART transmitter. Bytes written by the
//             host are queued in a circular buffer and handed to uart_tx one
//             at a time using a start pulse / busy handshake.
//  Options  : `define UART_TX_FIFO_OVF_EN adds an 8-bit saturating counter of
//             rejected writes (ovf_count) with a synchronous clear (ovf_clr).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic [7:0]    ovf_count,
    input  logic          ovf_clr
`endif
);

    // Only power-of-two depths in 2..256 let the pointers wrap by overflow.
    if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("uart_tx_fifo: DEPTH must be a power of two between 2 and 256");
    end

    localparam logic [AW:0]   c_full_count = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one    = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_tx_start;
    logic [7:0]    r_tx_data;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_pop;

    // Flags come from the registered count only, so a write while full is
    // rejected even when a pop frees a slot on the same edge.
    assign w_full   = (r_count == c_full_count);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en && !w_full;
    assign w_pop    = (r_state == IDLE) && !w_empty && !tx_busy;

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

    // Storage array; validity is tracked by count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous write and pop leave count as is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Handshake FSM with registered start pulse and held transmit byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_start <= 1'b0;
                    if (w_pop) begin
                        r_state    <= START;
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_mem[r_rd_ptr];
                    end
                end
                START: begin
                    r_state    <= WAIT_ACK;
                    r_tx_start <= 1'b0;
                end
                WAIT_ACK: begin
                    r_tx_start <= 1'b0;
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    r_tx_start <= 1'b0;
                    if (!tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic [7:0] r_ovf_count;
    logic       w_wr_rej;

    assign w_wr_rej  = wr_en && w_full;
    assign ovf_count = r_ovf_count;

    // Saturating count of dropped writes; clear wins over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_count <= 8'h00;
        end else if (ovf_clr) begin
            r_ovf_count <= 8'h00;
        end else if (w_wr_rej && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'h01;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Directed bench for uart_tx_fifo. Accepted bytes are queued as
//             expected transmissions; a monitor compares every tx_start
//             against the queue head. A small uart_tx model drives tx_busy.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
    logic [7:0]    ovf_count;
    logic          ovf_clr;
`endif

    int            total = 0;
    int            bad   = 0;
    logic [7:0]    sb[$];

    // uart_tx model: busy for busy_len cycles after each start pulse
    int            busy_len   = 10;
    int            m_cnt      = 0;
    logic          force_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf_count(ovf_count),
        .ovf_clr  (ovf_clr)
`endif
    );

    always @(posedge clk) begin
        if (tx_start) m_cnt <= busy_len;
        else if (m_cnt != 0) m_cnt <= m_cnt - 1;
    end
    assign tx_busy = force_busy || (m_cnt != 0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every start pulse must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst && tx_start) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got tx_data=%0h expected no pulse", tx_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (tx_data !== e) begin
                    bad++;
                    $display("FAIL tx_order: got=%0h expected=%0h", tx_data, e);
                end
            end
            total++;
            if (tx_busy !== 1'b0) begin
                bad++;
                $display("FAIL start_while_busy: tx_busy=%0b expected=0", tx_busy);
            end
        end
    end

    // Wait until everything expected has been sent and the link is quiet
    task automatic drain(input string nm, input int budget);
        int stable = 0;
        int n = 0;
        while (stable < 3 && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (sb.size() == 0 && empty && !tx_busy) stable++;
            else stable = 0;
        end
        total++;
        if (stable < 3) begin
            bad++;
            $display("FAIL %s_drain: left=%0d count=%0d expected 0 within %0d cycles",
                     nm, sb.size(), count, budget);
        end
        chk({nm, "_count0"}, 32'(count), 0);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b0;
`endif
        // Reset held with a write pending: nothing may be stored
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_count", 32'(count), 0);
            chk("rst_empty", 32'(empty), 1);
            chk("rst_full", 32'(full), 0);
            chk("rst_tx_start", 32'(tx_start), 0);
            chk("rst_tx_data", 32'(tx_data), 8'h00);
        end
`ifdef UART_TX_FIFO_OVF_EN
        chk("rst_ovf", 32'(ovf_count), 0);
`endif
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;

        // Single byte: start pulse on the second edge after the write
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("lat_count1", 32'(count), 1);
        chk("lat_no_start_yet", 32'(tx_start), 0);
        @(posedge clk); #1;
        chk("lat_start", 32'(tx_start), 1);
        chk("lat_data", 32'(tx_data), 8'hA5);
        chk("lat_count0", 32'(count), 0);
        @(posedge clk); #1;
        chk("lat_single_pulse", 32'(tx_start), 0);
        chk("lat_data_hold", 32'(tx_data), 8'hA5);
        drain("single", 100);

        // Four bytes back to back
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = 8'(i); sb.push_back(8'(i));
        end
        @(negedge clk); wr_en = 1'b0;
        drain("burst4", 200);

        // Fill while the transmitter is held busy; 17th byte is dropped
        @(negedge clk); force_busy = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = 8'(i);
            if (i < 16) sb.push_back(8'(i));
        end
        @(negedge clk); wr_en = 1'b0;
        @(posedge clk); #1;
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        chk("fill_empty", 32'(empty), 0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("fill_ovf1", 32'(ovf_count), 1);
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hEF; ovf_clr = 1'b1;
        @(posedge clk); #1;
        chk("ovf_clr_priority", 32'(ovf_count), 0);
        @(negedge clk); ovf_clr = 1'b0;
        @(posedge clk); #1;
        chk("ovf_incr", 32'(ovf_count), 1);
`endif
        // Write while full on the same edge as a pop: still rejected
        @(negedge clk); force_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
        @(posedge clk); #1;
        chk("fullpop_count", 32'(count), 15);
        chk("fullpop_start", 32'(tx_start), 1);
        chk("fullpop_data", 32'(tx_data), 8'h00);
`ifdef UART_TX_FIFO_OVF_EN
        chk("fullpop_ovf", 32'(ovf_count), 2);
`endif
        @(negedge clk); wr_en = 1'b0;
        drain("fill", 600);

        // Twenty bytes against a slow transmitter, pacing on full
        busy_len = 30;
        for (int i = 0; i < 20; i++) begin
            int w = 0;
            @(negedge clk);
            while (full && w < 200) begin
                wr_en = 1'b0;
                @(negedge clk);
                w++;
            end
            if (full) chk("wrap_full_timeout", 32'(full), 0);
            wr_en = 1'b1; wr_data = 8'h40 + 8'(i); sb.push_back(8'h40 + 8'(i));
        end
        @(negedge clk); wr_en = 1'b0;
        drain("wrap", 1200);

        // Reset while waiting on the transmitter with three bytes queued
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = 8'hC1 + 8'(i); sb.push_back(8'hC1 + 8'(i));
        end
        @(negedge clk); wr_en = 1'b0;
        begin
            int n = 0;
            while (!tx_busy && n < 50) begin @(posedge clk); #1; n++; end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_tx_busy", 32'(tx_busy), 1);
        chk("midrst_count3", 32'(count), 3);
        @(negedge clk); rst = 1'b1; sb.delete();
        #1;
        chk("midrst_async_count", 32'(count), 0);
        chk("midrst_async_empty", 32'(empty), 1);
        chk("midrst_async_start", 32'(tx_start), 0);
        chk("midrst_async_data", 32'(tx_data), 8'h00);
        @(negedge clk); rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("postrst_count", 32'(count), 0);
        chk("postrst_empty", 32'(empty), 1);
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h77; sb.push_back(8'h77);
        @(negedge clk); wr_en = 1'b0;
        drain("postrst", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; the block SHALL accept only powers of two from 2 to 256.
REQ-002 Parameter AW, default $clog2(DEPTH), pointer width; the block SHALL use this derived value and SHALL NOT expect it to be overridden.
REQ-003 clk  in  1  single system clock; all state SHALL be updated on its rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 wr_en  in  1  host write strobe, sampled each rising clk edge.
REQ-006 wr_data  in  8  byte to enqueue when wr_en=1.
REQ-007 full  out  1  high when count==DEPTH.
REQ-008 empty  out  1  high when count==0.
REQ-009 count  out  AW+1  number of stored bytes.
REQ-010 tx_start  out  1  single-cycle start pulse to uart_tx.
REQ-011 tx_data  out  8  byte presented to uart_tx data_in.
REQ-012 tx_busy  in  1  uart_tx busy flag.

Function
REQ-013 Storage SHALL be a circular buffer with AW-bit write/read pointers wrapping DEPTH-1 -> 0 and a registered count.
REQ-014 Write: wr_en=1 with full=0 SHALL store wr_data at wr_ptr, increment wr_ptr and count at that edge; wr_en=1 with full=1 SHALL be dropped with no state change.
REQ-015 full SHALL be evaluated from the registered count, so a write while full is rejected even if a pop occurs on the same edge.
REQ-016 Simultaneous accepted write and pop SHALL leave count unchanged and advance both pointers.
REQ-017 FSM states SHALL be IDLE, START, WAIT_ACK and WAIT_DONE.
REQ-018 IDLE -> START when empty=0 and tx_busy=0; otherwise stay in IDLE.
REQ-019 On the IDLE->START edge the FSM SHALL load tx_data from mem[rd_ptr], increment rd_ptr and decrement count (pop).
REQ-020 tx_start SHALL be 1 exactly during the START cycle, registered, with no combinational path from inputs.
REQ-021 START -> WAIT_ACK unconditionally.
REQ-022 WAIT_ACK -> WAIT_DONE when tx_busy=1; WAIT_ACK SHALL wait indefinitely otherwise.
REQ-023 WAIT_DONE -> IDLE when tx_busy=0.
REQ-024 tx_data SHALL hold stable from START until the next pop.
REQ-025 Latency: a byte written at edge N into an empty FIFO with tx_busy=0 SHALL see tx_start=1 in the cycle after edge N+1.
REQ-026 Consecutive bytes SHALL produce exactly one tx_start per byte, in FIFO order, and never while tx_busy=1.

Reset
REQ-027 rst=1 SHALL immediately clear pointers, count and memory-valid state, and force FSM=IDLE, tx_start=0, tx_data=8'h00, empty=1, full=0, count=0.
REQ-028 Reset mid-transfer SHALL discard all queued bytes and the in-flight byte; after release the FSM SHALL restart from IDLE without waiting on tx_busy history.

Configuration
REQ-029 Macro UART_TX_FIFO_OVF_EN: when defined, the block SHALL add output ovf_count (8) and input ovf_clr (1).
REQ-030 With UART_TX_FIFO_OVF_EN defined, each rejected write SHALL increment ovf_count, saturating at 8'hFF.
REQ-031 With UART_TX_FIFO_OVF_EN defined, ovf_clr=1 SHALL zero ovf_count and SHALL take priority over a same-cycle increment.
REQ-032 With UART_TX_FIFO_OVF_EN defined, reset SHALL set ovf_count to 0.
REQ-033 Without UART_TX_FIFO_OVF_EN, those ports and logic SHALL be absent and rejected writes SHALL be silently dropped.

Verification
REQ-034 Reset with wr_en=1, wr_data=8'h55 held -> count=0, empty=1, tx_start=0, tx_data=8'h00 throughout.
REQ-035 Write 8'hA5 once, uart_tx model busy for 10 cycles -> one tx_start with tx_data=8'hA5 two edges after the write; count returns to 0.
REQ-036 Write 8'h01..8'h04 back-to-back at DEPTH=16 -> four tx_start pulses carrying 01,02,03,04 in order, none while tx_busy=1.
REQ-037 Hold tx_busy=1, write 17 bytes 8'h00..8'h10 at DEPTH=16 -> full=1, count=16, byte 8'h10 dropped; with UART_TX_FIFO_OVF_EN defined, ovf_count=1.
REQ-038 Write 20 bytes with tx_busy=0 and a 30-cycle busy model -> pointer wrap exercised; output sequence matches input with no loss or duplication.
REQ-039 Assert rst in WAIT_DONE with 3 bytes queued -> FIFO empty, no further tx_start after release until a new write.
